// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared state type and mode encodings for the stream multiplexer
package stream_mux_pkg;
    typedef enum logic {IDLE, BUSY} mux_state_t;
    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;
endpackage

// File: rtl/stream_mux_n_1_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority search starting just after ptr
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);
    logic [SEL_W-1:0] w_idx;
    // walk from the lowest-priority offset up so the nearest requester after ptr wins
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = SEL_W'((int'(ptr) + k) % N);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/stream_mux_n_1.sv
// stream_mux_n_1: N:1 valid/ready stream mux with packet lock and registered output
module stream_mux_n_1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N),
    parameter int MODE  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready
);
    mux_state_t       r_state, w_next;
    logic [SEL_W-1:0] r_lock_ch, r_rr_ptr, r_out_ch, w_cand, w_g;
    logic [WIDTH-1:0] r_out_data, w_data;
    logic             r_out_last, r_out_valid;
    logic             w_cand_vld, w_g_vld, w_slot_free, w_fire, w_last;

    if (MODE == MODE_RR) begin : g_rr
        logic w_unused_sel;
        assign w_unused_sel = ^sel;
        rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
            .req     (in_valid),
            .ptr     (r_rr_ptr),
            .gnt_idx (w_cand),
            .gnt_vld (w_cand_vld)
        );
    end else begin : g_sel
        logic w_unused_rr;
        assign w_unused_rr = ^r_rr_ptr;
        assign w_cand      = sel;
        assign w_cand_vld  = |(in_valid & (N'(1) << sel));
    end

    assign w_slot_free = !r_out_valid | out_ready;
    assign w_g         = (r_state == BUSY) ? r_lock_ch : w_cand;
    assign w_g_vld     = (r_state == BUSY) | w_cand_vld;
    assign in_ready    = (rst || !w_slot_free || !w_g_vld) ? '0 : N'(1) << w_g;
    assign w_fire      = |(in_valid & in_ready);
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign out_ch      = r_out_ch;
    assign out_valid   = r_out_valid;

    // route the granted channel's beat toward the output register
    always_comb begin
        w_data = '0;
        w_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_ready[i]) begin
                w_data = in_data[i*WIDTH +: WIDTH];
                w_last = in_last[i];
            end
        end
    end

    // lock on a non-last beat, release on the last beat
    always_comb begin
        w_next = w_fire ? (w_last ? IDLE : BUSY) : r_state;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // remember the locked channel and the last packet winner for round-robin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_ch <= '0;
            r_rr_ptr  <= SEL_W'(N - 1);
        end else if (w_fire) begin
            r_lock_ch <= w_g;
            if (MODE == MODE_RR && w_last) r_rr_ptr <= w_g;
        end
    end

    // output slot: load on fire, otherwise drain when downstream accepts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_fire) begin
            r_out_data  <= w_data;
            r_out_last  <= w_last;
            r_out_ch    <= w_g;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_mux_n_1.sv
// tb_stream_mux_n_1: directed checks of select mode, round-robin mode and N=3 select mode
module tb_stream_mux_n_1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    logic [31:0] a_in_data, b_in_data;
    logic [3:0]  a_in_valid, a_in_last, a_in_ready, b_in_valid, b_in_last, b_in_ready;
    logic [1:0]  a_sel, a_out_ch, b_sel, b_out_ch;
    logic [7:0]  a_out_data, b_out_data;
    logic        a_out_last, a_out_valid, a_out_ready, b_out_last, b_out_valid, b_out_ready;
    logic [23:0] c_in_data;
    logic [2:0]  c_in_valid, c_in_last, c_in_ready;
    logic [1:0]  c_sel, c_out_ch;
    logic [7:0]  c_out_data;
    logic        c_out_last, c_out_valid, c_out_ready;

    stream_mux_n_1 #(.WIDTH(8), .N(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data), .out_last(a_out_last),
        .out_ch(a_out_ch), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );
    stream_mux_n_1 #(.WIDTH(8), .N(4), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data), .out_last(b_out_last),
        .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );
    stream_mux_n_1 #(.WIDTH(8), .N(3), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_last(c_in_last),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data), .out_last(c_out_last),
        .out_ch(c_out_ch), .out_valid(c_out_valid), .out_ready(c_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  h_v = '0;
    logic [3:0]  h_r = '0;
    logic [31:0] h_d = '0;
    // upstream obligation on the select-mode instance: a stalled beat keeps its data
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (!rst && h_v[i] && !h_r[i] && a_in_valid[i])
                check("hold", 32'(a_in_data[i*8 +: 8]), 32'(h_d[i*8 +: 8]));
        h_v <= a_in_valid;
        h_r <= a_in_ready;
        h_d <= a_in_data;
    end

    initial begin
        a_in_data = '0; a_in_valid = '0; a_in_last = '0; a_sel = '0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_valid = '0; b_in_last = '0; b_sel = '0; b_out_ready = 1'b1;
        c_in_data = '0; c_in_valid = '0; c_in_last = '0; c_sel = '0; c_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_valid", 32'(a_out_valid), 0);
        check("rst_a_data", 32'(a_out_data), 0);
        check("rst_b_ch", 32'(b_out_ch), 0);
        b_in_valid = 4'hF;
        #1;
        check("rst_b_ready", 32'(b_in_ready), 0);
        b_in_valid = '0;
        rst = 1'b0;
        #1;

        a_sel = 2'd2;
        a_in_data = 32'h00A1_5500;
        a_in_valid = 4'b0110;
        a_in_last = 4'b0010;
        #1;
        check("sel_rdy1", 32'(a_in_ready), 'h4);
        tick();
        check("sel_v1", 32'(a_out_valid), 1);
        check("sel_d1", 32'(a_out_data), 'hA1);
        check("sel_ch1", 32'(a_out_ch), 2);
        a_sel = 2'd1;
        a_in_data[23:16] = 8'hA2;
        #1;
        check("sel_rdy2", 32'(a_in_ready), 'h4);
        tick();
        check("sel_d2", 32'(a_out_data), 'hA2);
        check("sel_ch2", 32'(a_out_ch), 2);
        check("sel_v2", 32'(a_out_valid), 1);
        a_in_data[23:16] = 8'hA3;
        a_in_last[2] = 1'b1;
        #1;
        check("sel_rdy3", 32'(a_in_ready), 'h4);
        tick();
        check("sel_d3", 32'(a_out_data), 'hA3);
        check("sel_l3", 32'(a_out_last), 1);
        check("sel_ch3", 32'(a_out_ch), 2);
        a_in_valid = 4'b0010;
        #1;
        check("sel_rdy_ch1", 32'(a_in_ready), 'h2);
        tick();
        check("sel_d_ch1", 32'(a_out_data), 'h55);
        check("sel_ch_ch1", 32'(a_out_ch), 1);
        a_in_valid = '0;
        tick();
        check("sel_drain", 32'(a_out_valid), 0);

        a_sel = 2'd0;
        a_in_last = '0;
        a_in_data[7:0] = 8'hB0;
        a_in_valid = 4'b0001;
        #1;
        check("bp_rdy0", 32'(a_in_ready), 'h1);
        tick();
        check("bp_d0", 32'(a_out_data), 'hB0);
        a_in_data[7:0] = 8'hB1;
        tick();
        check("bp_d1", 32'(a_out_data), 'hB1);
        a_out_ready = 1'b0;
        a_in_data[7:0] = 8'hB2;
        #1;
        check("bp_rdy_stall", 32'(a_in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_d", 32'(a_out_data), 'hB1);
            check("bp_hold_v", 32'(a_out_valid), 1);
            check("bp_hold_rdy", 32'(a_in_ready), 0);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_rdy_resume", 32'(a_in_ready), 'h1);
        tick();
        check("bp_d2", 32'(a_out_data), 'hB2);
        check("bp_v2", 32'(a_out_valid), 1);
        a_in_data[7:0] = 8'hB3;
        a_in_last[0] = 1'b1;
        tick();
        check("bp_d3", 32'(a_out_data), 'hB3);
        check("bp_l3", 32'(a_out_last), 1);
        a_in_valid = '0;
        tick();
        check("bp_drain", 32'(a_out_valid), 0);

        b_in_data = 32'h1312_1110;
        b_in_last = 4'hF;
        b_in_valid = 4'hF;
        #1;
        check("rr_rdy0", 32'(b_in_ready), 'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_v", 32'(b_out_valid), 1);
            check("rr_ch", 32'(b_out_ch), i % 4);
            check("rr_d", 32'(b_out_data), 'h10 + i % 4);
        end
        rst = 1'b1;
        #1;
        check("arst_v", 32'(b_out_valid), 0);
        check("arst_rdy", 32'(b_in_ready), 0);
        check("arst_d", 32'(b_out_data), 0);
        tick();
        rst = 1'b0;
        #1;
        check("arst_rdy_ch0", 32'(b_in_ready), 'h1);
        tick();
        check("arst_ch0", 32'(b_out_ch), 0);
        check("arst_d0", 32'(b_out_data), 'h10);

        b_in_valid = 4'b1010;
        b_in_last = 4'b1000;
        b_in_data = 32'h3300_2000;
        #1;
        check("blk_rdy0", 32'(b_in_ready), 'h2);
        tick();
        check("blk_d0", 32'(b_out_data), 'h20);
        check("blk_ch0", 32'(b_out_ch), 1);
        for (int k = 1; k <= 5; k++) begin
            b_in_data[15:8] = 8'(8'h20 + k);
            b_in_last[1] = (k == 5);
            #1;
            check("blk_rdy", 32'(b_in_ready), 'h2);
            tick();
            check("blk_d", 32'(b_out_data), 'h20 + k);
            check("blk_ch", 32'(b_out_ch), 1);
        end
        b_in_data[15:8] = 8'h2F;
        #1;
        check("blk_rdy_ch3", 32'(b_in_ready), 'h8);
        tick();
        check("blk_d_ch3", 32'(b_out_data), 'h33);
        check("blk_ch3", 32'(b_out_ch), 3);
        check("blk_rdy_next", 32'(b_in_ready), 'h2);
        tick();
        check("blk_d_next", 32'(b_out_data), 'h2F);
        check("blk_ch_next", 32'(b_out_ch), 1);
        b_in_valid = '0;

        c_sel = 2'd3;
        c_in_valid = 3'b111;
        c_in_last = 3'b111;
        c_in_data = 24'h2A1B0C;
        #1;
        check("n3_rdy", 32'(c_in_ready), 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("n3_v", 32'(c_out_valid), 0);
            check("n3_rdy_hold", 32'(c_in_ready), 0);
        end
        c_sel = 2'd2;
        #1;
        check("n3_rdy_ch2", 32'(c_in_ready), 'h4);
        tick();
        check("n3_d_ch2", 32'(c_out_data), 'h2A);
        check("n3_ch2", 32'(c_out_ch), 2);
        c_in_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
